// File: rtl/share_bus_pkg.sv
// share_bus_pkg: shared line bus widths, parity lane size and transmitter state type
package share_bus_pkg;
   localparam int SHARE_DATA_W = 512;
   localparam int SHARE_LEN_W = 8;
   localparam int SHARE_PAR_LANE_W = 64;
   typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
endpackage

// File: rtl/share_tx_fifo.sv
// share_tx_fifo: DATA_W x DEPTH synchronous FIFO; a push while full is dropped, so a full-cycle pop frees the slot only next cycle
module share_tx_fifo #(
   parameter int DATA_W = 512,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic wr, rd;
   assign wr = push & ~full;
   assign rd = pop & ~empty;
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout = mem[rp];
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         wp <= wp + AW'(wr);
         rp <= rp + AW'(rd);
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/share_bus_tx.sv
// share_bus_tx: framed line transmitter onto the shared bus; define SHARE_TX_PARITY_EN for per-64b-lane even parity output
module share_bus_tx
   import share_bus_pkg::*;
#(
   parameter int DATA_W = SHARE_DATA_W,
   parameter int LEN_W = SHARE_LEN_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              Start_i,
   input  logic [LEN_W-1:0]  FrameLen_i,
   output logic              Busy_o,
   output logic              Done_o,
   input  logic              SrcValid_i,
   input  logic [DATA_W-1:0] SrcData_i,
   output logic              SrcReady_o,
   output logic              ShareValid_o,
   output logic [DATA_W-1:0] ShareLine_o,
   output logic              ShareFirst_o,
   output logic              ShareLast_o,
`ifdef SHARE_TX_PARITY_EN
   output logic [DATA_W/SHARE_PAR_LANE_W-1:0] ShareParity_o,
`endif
   input  logic              Halt_i
);
   tx_state_t state, state_nxt;
   logic [LEN_W-1:0] len, sent;
   logic [DATA_W-1:0] head;
   logic full, empty, upd, load, accept, start;
   share_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rstn(rstn), .push(SrcValid_i), .din(SrcData_i),
      .pop(load), .dout(head), .full(full), .empty(empty)
   );
   assign SrcReady_o = ~full;
   assign upd = ~ShareValid_o | ~Halt_i;
   assign load = upd & (state == SEND) & (sent < len) & ~empty;
   assign accept = ShareValid_o & ~Halt_i;
   assign start = (state == IDLE) & Start_i & (FrameLen_i != '0);
   assign Busy_o = state == SEND;
   assign Done_o = state == DONE;
   always_comb begin
      state_nxt = start ? SEND :
                  (state == SEND) ? ((accept & ShareLast_o) ? DONE : SEND) :
                  (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nxt;
   // sent counts lines loaded into the output register, so it never exceeds len
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len <= '0;
         sent <= '0;
         ShareValid_o <= 1'b0;
         ShareFirst_o <= 1'b0;
         ShareLast_o <= 1'b0;
         ShareLine_o <= '0;
      end else begin
         if (start) begin
            len <= FrameLen_i;
            sent <= '0;
         end else if (load) sent <= sent + 1'b1;
         if (upd) begin
            ShareValid_o <= load;
            ShareFirst_o <= load & (sent == '0);
            ShareLast_o <= load & (sent == len - 1'b1);
            if (load) ShareLine_o <= head;
         end
      end
   end
`ifdef SHARE_TX_PARITY_EN
   localparam int LANES = DATA_W / SHARE_PAR_LANE_W;
   logic [LANES-1:0] par;
   for (genvar i = 0; i < LANES; i++) begin : g_par
      assign par[i] = ^head[i*SHARE_PAR_LANE_W +: SHARE_PAR_LANE_W];
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) ShareParity_o <= '0;
      else if (load) ShareParity_o <= par;
`endif
endmodule

// File: tb/tb_share_bus_tx.sv
// tb_share_bus_tx: table-driven frames checked against a scoreboard of expected bus beats
module tb_share_bus_tx;
   localparam int DW = 512;
   localparam int LW = 8;
   typedef struct {
      logic [DW-1:0] line;
      logic          first;
      logic          last;
   } beat_t;
   typedef struct {
      int len;
      int gap;
      bit preload;
      int halt_beat;
      int halt_cyc;
      bit zero_start;
      bit mid_start;
      int exp_beats;
   } vec_t;
   logic clk = 1'b0, rstn = 1'b0, Start_i = 1'b0, SrcValid_i = 1'b0, Halt_i = 1'b0;
   logic [LW-1:0] FrameLen_i = '0;
   logic [DW-1:0] SrcData_i = '0;
   logic Busy_o, Done_o, SrcReady_o, ShareValid_o, ShareFirst_o, ShareLast_o;
   logic [DW-1:0] ShareLine_o;
   beat_t sb[$];
   beat_t e;
   int tests = 0, fails = 0, beat_idx = 0, halt_beat = -1, halt_left = 0, acc_cnt = 0, done_cnt = 0;
   logic p_valid = 1'b0, p_halt = 1'b0, p_first = 1'b0, p_last = 1'b0;
   logic [DW-1:0] p_line = '0;
   vec_t vecs[6];
   always #5 clk = ~clk;
   share_bus_tx dut (
      .clk(clk), .rstn(rstn), .Start_i(Start_i), .FrameLen_i(FrameLen_i),
      .Busy_o(Busy_o), .Done_o(Done_o), .SrcValid_i(SrcValid_i), .SrcData_i(SrcData_i),
      .SrcReady_o(SrcReady_o), .ShareValid_o(ShareValid_o), .ShareLine_o(ShareLine_o),
      .ShareFirst_o(ShareFirst_o), .ShareLast_o(ShareLast_o), .Halt_i(Halt_i)
   );
   function automatic void chkl(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction
   function automatic void chkb(string name, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction
   function automatic void chki(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction
   // bus-side monitor: drives Halt_i, checks hold while halted, pops the scoreboard on each accepted beat
   always @(negedge clk) begin
      if (!rstn) begin
         beat_idx = 0;
         halt_left = 0;
         Halt_i = 1'b0;
         p_valid = 1'b0;
         p_halt = 1'b0;
      end else begin
         if (p_valid && p_halt) begin
            chkb("hold_valid", ShareValid_o, 1'b1);
            chkl("hold_line", ShareLine_o, p_line);
            chkb("hold_first", ShareFirst_o, p_first);
            chkb("hold_last", ShareLast_o, p_last);
         end
         Halt_i = ShareValid_o && beat_idx == halt_beat && halt_left > 0;
         if (Halt_i) halt_left--;
         if (ShareValid_o && !Halt_i) begin
            acc_cnt++;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got line %h expected no beat", ShareLine_o);
            end else begin
               e = sb.pop_front();
               chkl("beat_line", ShareLine_o, e.line);
               chkb("beat_first", ShareFirst_o, e.first);
               chkb("beat_last", ShareLast_o, e.last);
            end
            beat_idx++;
         end
         if (Done_o) begin
            done_cnt++;
            beat_idx = 0;
         end
         p_valid = ShareValid_o;
         p_halt = Halt_i;
         p_line = ShareLine_o;
         p_first = ShareFirst_o;
         p_last = ShareLast_o;
      end
   end
   task automatic push_line(input bit first, input bit last);
      beat_t b;
      for (int i = 0; i < DW / 32; i++) b.line[i*32 +: 32] = $urandom;
      b.first = first;
      b.last = last;
      sb.push_back(b);
      SrcValid_i = 1'b1;
      SrcData_i = b.line;
      for (int n = 0; !SrcReady_o; n++) begin
         if (n == 100) begin
            tests++;
            fails++;
            $display("FAIL src_ready_timeout: got SrcReady_o 0 expected 1");
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      SrcValid_i = 1'b0;
   endtask
   task automatic run_vec(input vec_t v, input int idx);
      bit got = 0;
      int a0;
      halt_beat = v.halt_beat;
      halt_left = v.halt_cyc;
      if (v.preload)
         for (int k = 0; k < v.len; k++) push_line(k == 0, k == v.len - 1);
      if (v.zero_start) begin
         Start_i = 1'b1;
         FrameLen_i = '0;
         @(negedge clk);
         Start_i = 1'b0;
         @(negedge clk);
         chkb($sformatf("v%0d_zero_len_busy", idx), Busy_o, 1'b0);
      end
      a0 = acc_cnt;
      Start_i = 1'b1;
      FrameLen_i = LW'(v.len);
      @(negedge clk);
      Start_i = 1'b0;
      if (!v.preload)
         for (int k = 0; k < v.len; k++) begin
            push_line(k == 0, k == v.len - 1);
            if (k < v.len - 1) repeat (v.gap) @(negedge clk);
         end
      FrameLen_i = 8'd2;
      for (int i = 0; i < 300; i++) begin
         if (Done_o) begin
            got = 1;
            break;
         end
         chkb($sformatf("v%0d_busy", idx), Busy_o, 1'b1);
         Start_i = v.mid_start && i == 2;
         @(negedge clk);
      end
      Start_i = 1'b0;
      chkb($sformatf("v%0d_done_seen", idx), got, 1'b1);
      chkb($sformatf("v%0d_done_busy", idx), Busy_o, 1'b0);
      chki($sformatf("v%0d_sb_drained", idx), sb.size(), 0);
      @(negedge clk);
      chkb($sformatf("v%0d_done_pulse", idx), Done_o, 1'b0);
      chki($sformatf("v%0d_beats", idx), acc_cnt - a0, v.exp_beats);
      halt_beat = -1;
   endtask
   initial begin
      bit got;
      int a0, d0;
      vec_t rv;
      vecs[0] = '{4, 0, 1, -1, 0, 0, 0, 4};
      vecs[1] = '{1, 0, 1, -1, 0, 0, 0, 1};
      vecs[2] = '{4, 0, 1, 1, 3, 0, 0, 4};
      vecs[3] = '{3, 3, 0, -1, 0, 0, 0, 3};
      vecs[4] = '{3, 0, 1, -1, 0, 1, 1, 3};
      vecs[5] = '{5, 1, 0, 4, 2, 0, 0, 5};
      repeat (3) @(negedge clk);
      chkb("rst_valid", ShareValid_o, 1'b0);
      chkb("rst_first", ShareFirst_o, 1'b0);
      chkb("rst_last", ShareLast_o, 1'b0);
      chkl("rst_line", ShareLine_o, '0);
      chkb("rst_busy", Busy_o, 1'b0);
      chkb("rst_done", Done_o, 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      chkb("rst_src_ready", SrcReady_o, 1'b1);
      for (int v = 0; v < 6; v++) run_vec(vecs[v], v);
      for (int k = 0; k < 4; k++) push_line(k == 0, k == 3);
      a0 = acc_cnt;
      got = 0;
      Start_i = 1'b1;
      FrameLen_i = 8'd4;
      @(negedge clk);
      Start_i = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt - a0 >= 2) begin
            got = 1;
            break;
         end
      end
      chkb("mid_rst_two_beats", got, 1'b1);
      rstn = 1'b0;
      #1;
      chkb("mid_rst_valid", ShareValid_o, 1'b0);
      chkb("mid_rst_first", ShareFirst_o, 1'b0);
      chkb("mid_rst_last", ShareLast_o, 1'b0);
      chkl("mid_rst_line", ShareLine_o, '0);
      chkb("mid_rst_busy", Busy_o, 1'b0);
      chkb("mid_rst_done", Done_o, 1'b0);
      d0 = done_cnt;
      sb.delete();
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      chki("mid_rst_no_done", done_cnt - d0, 0);
      chkb("mid_rst_idle", Busy_o, 1'b0);
      chkb("mid_rst_fifo_ready", SrcReady_o, 1'b1);
      rv = '{2, 0, 1, -1, 0, 0, 0, 2};
      run_vec(rv, 6);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
